// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: Diff = (A - B - Bin) mod 2^N, computed LSB
//   first, one bit per clock, through a single full-subtractor stage whose
//   borrow is held in a register. An operation takes N cycles from accept to
//   done. The result is held until the next operation completes.
//
// Parameters
//   N     operand/result width in bits (N >= 2)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (overrides start, aborts SHIFT)
//   start  request, sampled only while idle
//   A, B   minuend / subtrahend, captured on the accepted start
//   Bin    borrow-in, captured on the accepted start
//   Diff   difference, updated only on the final shift edge
//   Bout   final borrow-out (A < B + Bin, unsigned)
//   Ovf    signed overflow of A - B - Bin (only with SERIAL_SUB_OVF_EN)
//   busy   high while shifting
//   done   one-cycle pulse, result valid from this cycle onward
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the Ovf output).
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic         Ovf,
`endif
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [N-1:0]    a_sh;    // minuend shifting out; result bits shift in at MSB
    logic [N-1:0]    b_sh;
    logic            borrow;
    logic [CW-1:0]   cnt;

    logic            d;
    logic            bo;
    logic            last;

    // Full-subtractor stage on the current LSBs.
    assign d    = a_sh[0] ^ b_sh[0] ^ borrow;
    assign bo   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            Ovf    <= 1'b0;
`endif
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The A register doubles as the result register: each
                    // consumed minuend bit frees the MSB for the new
                    // difference bit, so after N shifts it holds the result.
                    a_sh   <= {d, a_sh[N-1:1]};
                    b_sh   <= b_sh >> 1;
                    borrow <= bo;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Diff  <= {d, a_sh[N-1:1]};
                        Bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        // borrow still holds the borrow into the MSB stage here
                        Ovf   <= borrow ^ bo;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start_v;
    logic [15:0] a_in, b_in;
    logic        bin_in;

    logic [7:0]  diff8;
    logic [15:0] diff16;
    logic        bout8, bout16, busy8, busy16, done8, done16;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf16;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .A(a_in[7:0]), .B(b_in[7:0]), .Bin(bin_in),
        .Diff(diff8), .Bout(bout8),
`ifdef SERIAL_SUB_OVF_EN
        .Ovf(ovf8),
`endif
        .busy(busy8), .done(done8)
    );

    serial_subtractor #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .A(a_in), .B(b_in), .Bin(bin_in),
        .Diff(diff16), .Bout(bout16),
`ifdef SERIAL_SUB_OVF_EN
        .Ovf(ovf16),
`endif
        .busy(busy16), .done(done16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per DUT: cycles remaining in the current operation, the pending result
    // computed with plain integer arithmetic at accept, and the visible outputs.
    int          m_rem  [2] = '{0, 0};
    logic [15:0] m_diff [2] = '{16'h0, 16'h0};
    logic [15:0] p_diff [2] = '{16'h0, 16'h0};
    bit          m_bout [2] = '{0, 0};
    bit          p_bout [2] = '{0, 0};
    bit          m_ovf  [2] = '{0, 0};
    bit          p_ovf  [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int w, full, sa, sb, sres;
            int mask;
            w    = (i == 0) ? 8 : 16;
            mask = (1 << w) - 1;
            if (rst) begin
                m_rem[i] = 0; m_diff[i] = 0; m_bout[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_diff[i] = p_diff[i];
                        m_bout[i] = p_bout[i];
                        m_ovf[i]  = p_ovf[i];
                        m_done[i] = 1;
                    end
                end else if (start_v[i]) begin
                    m_rem[i] = w;
                    full = (int'(a_in) & mask) - (int'(b_in) & mask) - int'(bin_in);
                    p_diff[i] = 16'(full & mask);
                    p_bout[i] = (full < 0);
                    // signed interpretation of the operands
                    sa = int'(a_in) & mask; if (sa >= (1 << (w - 1))) sa -= (1 << w);
                    sb = int'(b_in) & mask; if (sb >= (1 << (w - 1))) sb -= (1 << w);
                    sres = sa - sb - int'(bin_in);
                    p_ovf[i] = (sres < -(1 << (w - 1))) || (sres > (1 << (w - 1)) - 1);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8",  {31'b0, busy8},  {31'b0, m_rem[0] > 0});
            chk("done8",  {31'b0, done8},  {31'b0, m_done[0]});
            chk("diff8",  {24'b0, diff8},  {24'b0, m_diff[0][7:0]});
            chk("bout8",  {31'b0, bout8},  {31'b0, m_bout[0]});
            chk("busy16", {31'b0, busy16}, {31'b0, m_rem[1] > 0});
            chk("done16", {31'b0, done16}, {31'b0, m_done[1]});
            chk("diff16", {16'b0, diff16}, {16'b0, m_diff[1]});
            chk("bout16", {31'b0, bout16}, {31'b0, m_bout[1]});
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf8",   {31'b0, ovf8},   {31'b0, m_ovf[0]});
            chk("ovf16",  {31'b0, ovf16},  {31'b0, m_ovf[1]});
`endif
        end
    end

    function automatic bit done_of(input int i);
        return (i == 0) ? done8 : done16;
    endfunction

    // Called just after a posedge: start pulse, then wait (bounded) for done.
    // lat = edges from the accepting edge to the edge that raised done.
    task automatic run(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, output int lat);
        a_in = a; b_in = b; bin_in = bin;
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        lat = 0;
        while (!done_of(i) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, ndone;
        rst = 1'b1; start_v = 2'b00; a_in = '0; b_in = '0; bin_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_diff", {24'b0, diff8}, 32'd0);
        chk("rst_bout", {31'b0, bout8}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // basic
        run(0, 16'd100, 16'd37, 1'b0, lat);
        chk("basic_lat",  lat, 32'd8);
        chk("basic_diff", {24'b0, diff8}, 32'd63);
        chk("basic_bout", {31'b0, bout8}, 32'd0);

        // underflow and borrow boundaries
        run(0, 16'd37, 16'd100, 1'b0, lat);
        chk("uf1_diff", {24'b0, diff8}, 32'd193);
        chk("uf1_bout", {31'b0, bout8}, 32'd1);
        run(0, 16'd0, 16'd0, 1'b1, lat);
        chk("uf2_diff", {24'b0, diff8}, 32'd255);
        chk("uf2_bout", {31'b0, bout8}, 32'd1);
        run(0, 16'd255, 16'd0, 1'b0, lat);
        chk("max_diff", {24'b0, diff8}, 32'd255);
        chk("max_bout", {31'b0, bout8}, 32'd0);

        // handshake: start held high through SHIFT, re-accepted in done cycle
        a_in = 16'd100; b_in = 16'd37; bin_in = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        a_in = 16'd10; b_in = 16'd3;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("hs_one_done", ndone, 32'd1);
        chk("hs_diff1",    {24'b0, diff8}, 32'd63);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("hs_busy2",    {31'b0, busy8}, 32'd1);
        chk("hs_hold",     {24'b0, diff8}, 32'd63);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hs_lat2",  lat, 32'd8);
        chk("hs_diff2", {24'b0, diff8}, 32'd7);

        // reset in the 4th SHIFT cycle
        a_in = 16'd200; b_in = 16'd1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ra_busy", {31'b0, busy8}, 32'd0);
        chk("ra_done", {31'b0, done8}, 32'd0);
        chk("ra_diff", {24'b0, diff8}, 32'd0);
        chk("ra_bout", {31'b0, bout8}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("ra_no_done", ndone, 32'd0);
        run(0, 16'd100, 16'd37, 1'b0, lat);
        chk("ra_lat",  lat, 32'd8);
        chk("ra_diff2", {24'b0, diff8}, 32'd63);

        // 16-bit literal boundary
        run(1, 16'h0000, 16'h0001, 1'b0, lat);
        chk("w16_lat",  lat, 32'd16);
        chk("w16_diff", {16'b0, diff16}, 32'hFFFF);
        chk("w16_bout", {31'b0, bout16}, 32'd1);

`ifdef SERIAL_SUB_OVF_EN
        run(0, 16'h80, 16'h01, 1'b0, lat);
        chk("ovf1_diff", {24'b0, diff8}, 32'h7F);
        chk("ovf1",      {31'b0, ovf8},  32'd1);
        run(0, 16'h7F, 16'hFF, 1'b0, lat);
        chk("ovf2_diff", {24'b0, diff8}, 32'h80);
        chk("ovf2",      {31'b0, ovf8},  32'd1);
        run(0, 16'd5, 16'd3, 1'b0, lat);
        chk("ovf3",      {31'b0, ovf8},  32'd0);
`endif

        // random: 500 per width, checked by the per-cycle compare
        for (int k = 0; k < 1000; k++) begin
            run(k & 1, 16'($urandom), 16'($urandom), 1'($urandom), lat);
            if (lat != ((k & 1) ? 16 : 8))
                chk("rnd_lat", lat, (k & 1) ? 32'd16 : 32'd8);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes Diff = A − B − Bin, LSB first, one bit per clock.
- Uses a single full-subtractor stage with a registered borrow.
- It is the subtraction counterpart of the team's adder datapath. It serves low-area arithmetic paths where an N-cycle latency is acceptable.
- Start/done handshake; the result is held until the next operation.

Parameters:
- N, 8, operand and result width in bits (N ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  minuend; captured on the accepted start.
- B  input  N  subtrahend; captured on the accepted start.
- Bin  input  1  borrow-in; captured on the accepted start.
- Diff  output  N  difference (A − B − Bin) mod 2^N.
- Bout  output  1  final borrow-out (1 when A < B + Bin, unsigned).
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; the result is valid from this cycle onward.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst sampled high on a clk edge):
  - state = IDLE.
  - Diff = 0, Bout = 0, busy = 0, done = 0.
  - Operand shift registers, borrow register and bit counter cleared.
  - rst overrides start.
  - Reset during SHIFT aborts the operation: no done, no partial result exposed.
- Full-subtractor stage, with a = A bit, b = B bit, bi = borrow:
  - d = a ^ b ^ bi.
  - bo = (~a & b) | (~(a ^ b) & bi).
- States:
  - IDLE:
    - busy = 0.
    - On an edge with start = 1: load A, B into shift registers, load borrow register with Bin, counter = 0, go to SHIFT.
    - start = 0: stay in IDLE.
  - SHIFT:
    - busy = 1.
    - Each edge: compute d/bo on the LSBs.
    - Shift d into the MSB of the result register; shift A and B right.
    - Borrow register = bo; counter + 1.
    - On the edge where counter = N−1 (the N-th bit): go to IDLE, load Diff from the final result register, Bout = bo, done = 1.
- Timing:
  - Start accepted on edge k → busy high in cycles k+1 … k+N.
  - done high exactly one cycle, after edge k+N.
  - Latency is N cycles from accept to done.
- done clears on the next edge unconditionally.
- Diff and Bout are held stable until the next accepted operation completes. They do not change during SHIFT; only the final load updates them.
- Inputs:
  - start while busy is ignored; no queuing.
  - start high in the done cycle is accepted (state is already IDLE) → back-to-back throughput of one result per N cycles.
  - A, B and Bin changes after acceptance have no effect.
- Counter width is clog2(N); it never wraps within an operation and is reset to 0 on each accept.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port Ovf (output, 1 bit): signed (two's complement) overflow of A − B − Bin.
  - Ovf = borrow into MSB stage XOR borrow out of MSB stage, captured on the final SHIFT edge.
  - Same timing, reset (0) and hold rules as Bout.
- Undefined: the Ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: N=8, A=100, B=37, Bin=0, start pulse → busy for 8 cycles; done 8 cycles after accept; Diff=63, Bout=0.
- Underflow: A=37, B=100, Bin=0 → Diff=193, Bout=1. Then A=0, B=0, Bin=1 → Diff=255, Bout=1. Then A=255, B=0, Bin=0 → Diff=255, Bout=0.
- Handshake:
  - start held high through SHIFT → ignored; exactly one done.
  - start asserted in the done cycle with A=10, B=3 → second done 8 cycles later, Diff=7.
  - Diff stays 63 between the two results.
- Reset:
  - rst asserted at the 4th SHIFT cycle → next cycle busy=0, done=0, Diff=0, Bout=0, no done afterward.
  - A new start then completes normally.
- Random: 1000 random A, B, Bin (N=8 and N=16) compared against (A − B − Bin) mod 2^N and the unsigned-borrow reference model.
- With SERIAL_SUB_OVF_EN (N=8):
  - A=8'h80, B=1 → Diff=8'h7F, Ovf=1.
  - A=8'h7F, B=8'hFF → Diff=8'h80, Ovf=1.
  - A=5, B=3 → Ovf=0.
